// File: rtl/axi_ram_slave.sv
// AXI3 slave backed by a single-port, word-organised RAM: one read or write
// INCR burst (1..16 beats) in flight at a time, read/write arbitration alternates.
module axi_ram_slave #(
  parameter int ADDR_W = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t            state, state_next;
  logic [31:0]       mem [0:(2**ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic [3:0]        len, beat, txn_id;
  logic              prio_rd, err;
  logic              grant_rd, grant_wr;
  logic              ar_fire, aw_fire, r_fire, w_fire, w_done, beat_last;

  // Sideband fields and aliased address bits have no effect on behaviour.
  logic unused;
  assign unused = ^{arsize, arburst, arlock, arcache, arprot, arlen[7:4],
                    araddr[31:ADDR_W+2], araddr[1:0],
                    awsize, awburst, awlock, awcache, awprot, awlen[7:4],
                    awaddr[31:ADDR_W+2], awaddr[1:0], wid};

  assign grant_rd  = arvalid & (~awvalid | prio_rd);
  assign grant_wr  = awvalid & ~grant_rd;
  assign arready   = (state == IDLE) & grant_rd;
  assign awready   = (state == IDLE) & grant_wr;
  assign wready    = (state == WR);
  assign bvalid    = (state == WRESP);
  assign bresp     = (bvalid & err) ? 2'b10 : 2'b00;
  assign rresp     = 2'b00;
  assign rid       = txn_id;
  assign bid       = txn_id;

  assign ar_fire   = arvalid & arready;
  assign aw_fire   = awvalid & awready;
  assign r_fire    = rvalid & rready;
  assign w_fire    = wvalid & wready;
  assign beat_last = (beat == len);
  assign w_done    = w_fire & (wlast | beat_last);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ar_fire)             state_next = RD;
               else if (aw_fire)        state_next = WR;
      RD:      if (r_fire && rlast)     state_next = IDLE;
      WR:      if (w_done)              state_next = WRESP;
      WRESP:   if (bready)              state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx     <= '0;
      len     <= '0;
      beat    <= '0;
      txn_id  <= '0;
      prio_rd <= 1'b1;
      err     <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
    end else begin
      // Priority only flips when both sides actually competed.
      if (state == IDLE && arvalid && awvalid) prio_rd <= grant_wr;

      case (state)
        IDLE: begin
          if (ar_fire) begin
            txn_id <= arid;
            idx    <= araddr[ADDR_W+1:2];
            len    <= arlen[3:0];
            beat   <= '0;
          end else if (aw_fire) begin
            txn_id <= awid;
            idx    <= awaddr[ADDR_W+1:2];
            len    <= awlen[3:0];
            beat   <= '0;
            err    <= 1'b0;
          end
        end
        RD: begin
          // Alternate between an issue cycle (rvalid low) and a present cycle.
          if (!rvalid) begin
            rdata  <= mem[idx];
            rlast  <= beat_last;
            rvalid <= 1'b1;
            idx    <= idx + 1'b1;
          end else if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            beat   <= beat + 4'd1;
          end
        end
        WR: begin
          if (w_fire) begin
            idx  <= idx + 1'b1;
            beat <= beat + 4'd1;
            if (wlast != beat_last) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the RAM array has no reset; contents survive aresetn and start
  // undefined, exactly like the memory it models.
  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave (ADDR_W=4): stimulus pushes expected R/B
// responses into queues, a negedge monitor pops and compares them.
module tb_axi_ram_slave;

  localparam int BUDGET = 50;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = 2'b01;
  logic [1:0]  arlock = '0;
  logic [3:0]  arcache = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'b010;
  logic [1:0]  awburst = 2'b01;
  logic [1:0]  awlock = '0;
  logic [3:0]  awcache = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected R beat: {rid, rresp, rlast, rdata}; expected B: {bid, bresp}.
  logic [38:0] r_q [$];
  logic [5:0]  b_q [$];

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];

  axi_ram_slave #(.ADDR_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic ar_req(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!arready && n < BUDGET);
    check("ar_handshake", 64'(arready), 64'(1));
    tick();
    arvalid = 1'b0;
  endtask

  task automatic aw_req(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    do begin @(negedge aclk); n++; end while (!awready && n < BUDGET);
    check("aw_handshake", 64'(awready), 64'(1));
    tick();
    awvalid = 1'b0;
  endtask

  // Accept len+1 beats; beats flagged in stall see rready low for ~2 cycles.
  task automatic r_collect(input logic [3:0] len, input logic [15:0] stall, output int lat);
    int n;
    lat = 0;
    for (int i = 0; i <= int'(len); i++) begin
      rready = !stall[i];
      n = 0;
      do begin @(negedge aclk); n++; end while (!rvalid && n < BUDGET);
      if (i == 0) lat = n;
      if (!rvalid) begin
        check("r_timeout", 64'(rvalid), 64'(1));
        rready = 1'b0;
        return;
      end
      if (stall[i]) begin
        tick();
        tick();
        rready = 1'b1;
        @(negedge aclk);
      end
      tick();
    end
    rready = 1'b0;
  endtask

  task automatic w_send(input int beats);
    int n;
    for (int i = 0; i < beats; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!wready && n < BUDGET);
      if (!wready) begin
        check("w_timeout", 64'(wready), 64'(1));
        break;
      end
      tick();
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic b_wait(output int lat);
    int n = 0;
    do begin @(negedge aclk); n++; end while (!bvalid && n < BUDGET);
    lat = n;
    if (!bvalid) check("b_timeout", 64'(bvalid), 64'(1));
    else tick();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: compares every presented response against the queue
  // head (so stalled beats are checked for stability) and pops on handshake.
  initial begin : monitor
    forever begin
      @(negedge aclk);
      if (aresetn && rvalid) begin
        if (r_q.size() == 0) check("r_unexpected", 64'({rid, rresp, rlast, rdata}), 64'(0));
        else begin
          check("r_beat", 64'({rid, rresp, rlast, rdata}), 64'(r_q[0]));
          if (rready) void'(r_q.pop_front());
        end
      end
      if (aresetn && bvalid) begin
        if (b_q.size() == 0) check("b_unexpected", 64'({bid, bresp}), 64'(0));
        else begin
          check("b_resp", 64'({bid, bresp}), 64'(b_q[0]));
          if (bready) void'(b_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lat;
    logic got_rd;
    logic [2:0] exp_grant;
    int n;

    // Reset values, with both requests pending so the IDLE equations show prio_rd=1.
    arvalid = 1'b1; awvalid = 1'b1;
    @(negedge aclk);
    check("rst_outputs", 64'({rvalid, bvalid, wready, rlast, rid, bid, rresp, bresp}), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_arb_ready", 64'({arready, awready}), 64'(2'b10));
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();

    // Single write then read-back, with latency checks.
    b_q.push_back({4'h3, 2'b00});
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
    aw_req(32'h10, 8'h00, 4'h3);
    w_send(1);
    b_wait(lat);
    check("b_latency", 64'(lat), 64'(1));
    r_q.push_back({4'h5, 2'b00, 1'b1, 32'hDEADBEEF});
    ar_req(32'h10, 8'h00, 4'h5);
    r_collect(4'd0, 16'h0, lat);
    check("r_latency", 64'(lat), 64'(2));

    // Byte strobes.
    b_q.push_back({4'h1, 2'b00});
    wd[0] = 32'h11223344; ws[0] = 4'hF; wl[0] = 1'b1;
    aw_req(32'h20, 8'h00, 4'h1);
    w_send(1);
    b_wait(lat);
    b_q.push_back({4'h2, 2'b00});
    wd[0] = 32'h0000AA00; ws[0] = 4'h2; wl[0] = 1'b1;
    aw_req(32'h20, 8'h00, 4'h2);
    w_send(1);
    b_wait(lat);
    r_q.push_back({4'h4, 2'b00, 1'b1, 32'h1122AA44});
    ar_req(32'h20, 8'h00, 4'h4);
    r_collect(4'd0, 16'h0, lat);

    // 4-beat burst at 0x100 (aliases word 0); read back with beats 1 and 3 stalled,
    // upper arlen bits set to show they are ignored.
    b_q.push_back({4'h6, 2'b00});
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 3);
    end
    aw_req(32'h100, 8'h03, 4'h6);
    w_send(4);
    b_wait(lat);
    for (int i = 0; i < 4; i++) r_q.push_back({4'h7, 2'b00, (i == 3), 32'(i + 1)});
    ar_req(32'h100, 8'hF3, 4'h7);
    r_collect(4'd3, 16'b1010, lat);

    // Arbitration from reset with both requests valid each round: R, W, R.
    do_reset();
    exp_grant = 3'b101;
    for (int r = 0; r < 3; r++) begin
      arid = 4'h8; araddr = 32'h10; arlen = 8'h00; arvalid = 1'b1;
      awid = 4'h9; awaddr = 32'h30; awlen = 8'h00; awvalid = 1'b1;
      n = 0;
      do begin @(negedge aclk); n++; end while (!(arready || awready) && n < BUDGET);
      got_rd = arready;
      check("arb_grant", 64'({arready, awready}), 64'({exp_grant[r], !exp_grant[r]}));
      if (got_rd) r_q.push_back({4'h8, 2'b00, 1'b1, 32'hDEADBEEF});
      else        b_q.push_back({4'h9, 2'b00});
      tick();
      arvalid = 1'b0; awvalid = 1'b0;
      if (got_rd) r_collect(4'd0, 16'h0, lat);
      else begin
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF; wl[0] = 1'b1;
        w_send(1);
        b_wait(lat);
      end
    end
    r_q.push_back({4'hE, 2'b00, 1'b1, 32'hCAFEF00D});
    ar_req(32'h30, 8'h00, 4'hE);
    r_collect(4'd0, 16'h0, lat);

    // Index wrap: 2 beats from the last word, second lands in word 0.
    b_q.push_back({4'hA, 2'b00});
    wd[0] = 32'h11111111; ws[0] = 4'hF; wl[0] = 1'b0;
    wd[1] = 32'h22222222; ws[1] = 4'hF; wl[1] = 1'b1;
    aw_req(32'h3C, 8'h01, 4'hA);
    w_send(2);
    b_wait(lat);
    r_q.push_back({4'h1, 2'b00, 1'b1, 32'h22222222});
    ar_req(32'h00, 8'h00, 4'h1);
    r_collect(4'd0, 16'h0, lat);
    r_q.push_back({4'hD, 2'b00, 1'b0, 32'h11111111});
    r_q.push_back({4'hD, 2'b00, 1'b1, 32'h22222222});
    ar_req(32'h3C, 8'h01, 4'hD);
    r_collect(4'd1, 16'h0, lat);

    // Early wlast on beat 1 of a 3-beat burst gives SLVERR; next write is clean.
    b_q.push_back({4'hB, 2'b10});
    wd[0] = 32'h55; ws[0] = 4'hF; wl[0] = 1'b0;
    wd[1] = 32'h66; ws[1] = 4'hF; wl[1] = 1'b1;
    aw_req(32'h24, 8'h02, 4'hB);
    w_send(2);
    b_wait(lat);
    check("early_wlast_b_latency", 64'(lat), 64'(1));
    b_q.push_back({4'hC, 2'b00});
    wd[0] = 32'h77; ws[0] = 4'hF; wl[0] = 1'b1;
    aw_req(32'h28, 8'h00, 4'hC);
    w_send(1);
    b_wait(lat);
    r_q.push_back({4'h2, 2'b00, 1'b0, 32'h55});
    r_q.push_back({4'h2, 2'b00, 1'b1, 32'h77});
    ar_req(32'h24, 8'h01, 4'h2);
    r_collect(4'd1, 16'h0, lat);

    // Reset in the middle of a stalled read burst.
    r_q.push_back({4'hC, 2'b00, 1'b0, 32'h2});
    rready = 1'b0;
    ar_req(32'h104, 8'h03, 4'hC);
    n = 0;
    do begin @(negedge aclk); n++; end while (!rvalid && n < BUDGET);
    check("mid_burst_rvalid", 64'(rvalid), 64'(1));
    tick();
    aresetn = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(rvalid), 64'(0));
    check("rst_mid_pending", 64'(r_q.size()), 64'(1));
    r_q.delete();
    tick();
    aresetn = 1'b1;
    tick();
    r_q.push_back({4'h6, 2'b00, 1'b0, 32'h2});
    r_q.push_back({4'h6, 2'b00, 1'b1, 32'h3});
    ar_req(32'h104, 8'h01, 4'h6);
    r_collect(4'd1, 16'h0, lat);
    r_q.push_back({4'h9, 2'b00, 1'b1, 32'hDEADBEEF});
    ar_req(32'h10, 8'h00, 4'h9);
    r_collect(4'd0, 16'h0, lat);

    tick();
    tick();
    check("r_queue_drained", 64'(r_q.size()), 64'(0));
    check("b_queue_drained", 64'(b_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
